// File: rtl/axi_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axi_slave_pkg
// Brief   : Shared types and constants for the AXI slave write path.
// Revision: 1.0 - initial release
// ============================================================================
package axi_slave_pkg;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'd0,
      BURST_INCR  = 2'd1,
      BURST_WRAP  = 2'd2,
      BURST_RSVD  = 2'd3
   } burst_t;

   localparam logic [1:0] RESP_OKAY   = 2'd0;
   localparam logic [1:0] RESP_SLVERR = 2'd2;

   typedef logic [1:0] state_t;
   localparam state_t c_ST_IDLE = 2'd0;
   localparam state_t c_ST_DATA = 2'd1;
   localparam state_t c_ST_RESP = 2'd2;

   // WRAP bursts are only legal for 2, 4, 8 or 16 beats
   function automatic logic wrap_len_ok(input logic [7:0] len);
      return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
   endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module  : axi_burst_addr_gen
// Brief   : Combinational next-beat address for FIXED / INCR / WRAP bursts.
// Revision: 1.0 - initial release
// ============================================================================
module axi_burst_addr_gen
   import axi_slave_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [2:0]        i_size,
   input  logic [7:0]        i_len,
   input  logic [1:0]        i_burst,
   output logic [ADDR_W-1:0] o_next_addr
);

   localparam logic [ADDR_W-1:0] c_ONE = ADDR_W'(1);

   logic [ADDR_W-1:0] w_step;
   logic [ADDR_W-1:0] w_sum;
   logic [ADDR_W-1:0] w_win_mask;

   always_comb begin
      w_step      = c_ONE << i_size;
      w_sum       = i_addr + w_step;
      w_win_mask  = ((ADDR_W'(i_len) + c_ONE) << i_size) - c_ONE;
      o_next_addr = w_sum;
      case (i_burst)
         BURST_FIXED: o_next_addr = i_addr;
         BURST_WRAP: begin
            // Illegal WRAP lengths fall back to INCR addressing
            if (wrap_len_ok(i_len))
               o_next_addr = (i_addr & ~w_win_mask) | (w_sum & w_win_mask);
         end
         default: o_next_addr = w_sum;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/axi_slave_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : axi_slave_write_ctrl
// Brief   : AXI slave write sequencer: AW latch, per-beat address, B response.
//           Optional WLAST_CHECK_EN flags misplaced wlast as SLVERR.
// Revision: 1.0 - initial release
// ============================================================================
module axi_slave_write_ctrl
   import axi_slave_pkg::*;
#(
   parameter  int ADDR_W = 32,
   parameter  int DATA_W = 32,
   parameter  int ID_W   = 12,
   localparam int STRB_W = DATA_W / 8
) (
   input  logic              clk,
   input  logic              s_axi_aresetn,
   input  logic              s_axi_awvalid,
   output logic              s_axi_awready,
   input  logic [ADDR_W-1:0] s_axi_awaddr,
   input  logic [7:0]        s_axi_awlen,
   input  logic [2:0]        s_axi_awsize,
   input  logic [1:0]        s_axi_awburst,
   input  logic [ID_W-1:0]   s_axi_awid,
   input  logic              s_axi_wvalid,
   output logic              s_axi_wready,
   input  logic [DATA_W-1:0] s_axi_wdata,
   input  logic [STRB_W-1:0] s_axi_wstrb,
   input  logic              s_axi_wlast,
   output logic              s_axi_bvalid,
   input  logic              s_axi_bready,
   output logic [ID_W-1:0]   s_axi_bid,
   output logic [1:0]        s_axi_bresp,
   input  logic              write_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [STRB_W-1:0] wr_strb
);

   state_t            r_state;
   logic              r_awready;
   logic [ADDR_W-1:0] r_addr;
   logic [7:0]        r_len;
   logic [2:0]        r_size;
   logic [1:0]        r_burst;
   logic [ID_W-1:0]   r_id;
   logic [7:0]        r_cnt;
   logic              r_err;
   logic              r_bvalid;
   logic [1:0]        r_bresp;

   logic [ADDR_W-1:0] w_next_addr;
   logic              w_last_beat;
   logic              w_aw_illegal;
   logic              w_wlast_err;

   axi_burst_addr_gen #(
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .i_addr      (r_addr),
      .i_size      (r_size),
      .i_len       (r_len),
      .i_burst     (r_burst),
      .o_next_addr (w_next_addr)
   );

   assign w_last_beat  = (r_cnt == r_len);
   assign w_aw_illegal = (s_axi_awburst == BURST_RSVD) ||
                         ((s_axi_awburst == BURST_WRAP) && !wrap_len_ok(s_axi_awlen));

`ifdef WLAST_CHECK_EN
   assign w_wlast_err = (s_axi_wlast != w_last_beat);
`else
   logic w_unused_wlast;
   assign w_unused_wlast = s_axi_wlast;
   assign w_wlast_err    = 1'b0;
`endif

   assign s_axi_awready = r_awready;
   assign s_axi_wready  = (r_state == c_ST_DATA) && write_ready;
   assign wr_en         = s_axi_wvalid && s_axi_wready;
   assign wr_addr       = r_addr;
   assign wr_data       = s_axi_wdata;
   assign wr_strb       = s_axi_wstrb;
   assign s_axi_bvalid  = r_bvalid;
   assign s_axi_bid     = r_id;
   assign s_axi_bresp   = r_bresp;

   always_ff @(posedge clk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         r_state   <= c_ST_IDLE;
         r_awready <= 1'b0;
         r_addr    <= '0;
         r_len     <= '0;
         r_size    <= '0;
         r_burst   <= '0;
         r_id      <= '0;
         r_cnt     <= '0;
         r_err     <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bresp   <= RESP_OKAY;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               r_awready <= 1'b1;
               if (s_axi_awvalid && r_awready) begin
                  r_addr    <= s_axi_awaddr;
                  r_len     <= s_axi_awlen;
                  r_size    <= s_axi_awsize;
                  r_burst   <= s_axi_awburst;
                  r_id      <= s_axi_awid;
                  r_cnt     <= '0;
                  r_err     <= w_aw_illegal;
                  r_awready <= 1'b0;
                  r_state   <= c_ST_DATA;
               end
            end
            c_ST_DATA: begin
               if (wr_en) begin
                  r_addr <= w_next_addr;
                  if (w_last_beat) begin
                     r_bvalid <= 1'b1;
                     r_bresp  <= (r_err || w_wlast_err) ? RESP_SLVERR : RESP_OKAY;
                     r_state  <= c_ST_RESP;
                  end else begin
                     r_cnt <= r_cnt + 8'd1;
                     r_err <= r_err || w_wlast_err;
                  end
               end
            end
            c_ST_RESP: begin
               if (s_axi_bready) begin
                  r_bvalid  <= 1'b0;
                  r_awready <= 1'b1;
                  r_state   <= c_ST_IDLE;
               end
            end
            default: r_state <= c_ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_axi_slave_write_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_axi_slave_write_ctrl
// Brief   : Randomized bench for axi_slave_write_ctrl against a burst model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_axi_slave_write_ctrl;

   logic        clk = 1'b0;
   logic        s_axi_aresetn;
   logic        s_axi_awvalid;
   logic        s_axi_awready;
   logic [31:0] s_axi_awaddr;
   logic [7:0]  s_axi_awlen;
   logic [2:0]  s_axi_awsize;
   logic [1:0]  s_axi_awburst;
   logic [11:0] s_axi_awid;
   logic        s_axi_wvalid;
   logic        s_axi_wready;
   logic [31:0] s_axi_wdata;
   logic [3:0]  s_axi_wstrb;
   logic        s_axi_wlast;
   logic        s_axi_bvalid;
   logic        s_axi_bready;
   logic [11:0] s_axi_bid;
   logic [1:0]  s_axi_bresp;
   logic        write_ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;

   int n_pass = 0;
   int n_chk  = 0;

   always #5 clk = ~clk;

   axi_slave_write_ctrl #(
      .ADDR_W (32),
      .DATA_W (32),
      .ID_W   (12)
   ) u_dut (
      .clk           (clk),
      .s_axi_aresetn (s_axi_aresetn),
      .s_axi_awvalid (s_axi_awvalid),
      .s_axi_awready (s_axi_awready),
      .s_axi_awaddr  (s_axi_awaddr),
      .s_axi_awlen   (s_axi_awlen),
      .s_axi_awsize  (s_axi_awsize),
      .s_axi_awburst (s_axi_awburst),
      .s_axi_awid    (s_axi_awid),
      .s_axi_wvalid  (s_axi_wvalid),
      .s_axi_wready  (s_axi_wready),
      .s_axi_wdata   (s_axi_wdata),
      .s_axi_wstrb   (s_axi_wstrb),
      .s_axi_wlast   (s_axi_wlast),
      .s_axi_bvalid  (s_axi_bvalid),
      .s_axi_bready  (s_axi_bready),
      .s_axi_bid     (s_axi_bid),
      .s_axi_bresp   (s_axi_bresp),
      .write_ready   (write_ready),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .wr_strb       (wr_strb)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
   endtask

   function automatic logic is_wrap_len(input int len);
      return (len == 1) || (len == 3) || (len == 7) || (len == 15);
   endfunction

   // Address of beat i, straight from the burst-type definitions
   function automatic logic [31:0] exp_addr(input logic [31:0] a, input int len,
                                            input int sz, input int bt, input int i);
      int unsigned bytes;
      int unsigned win;
      int unsigned base;
      bytes = 1 << sz;
      if (bt == 0) return a;
      if (bt == 2 && is_wrap_len(len)) begin
         win  = (len + 1) * bytes;
         base = a - (a % win);
         return base + ((a - base + i * bytes) % win);
      end
      return a + i * bytes;
   endfunction

   function automatic logic [1:0] exp_resp(input int len, input int bt, input int bad_last);
      if (bt == 3) return 2'd2;
      if (bt == 2 && !is_wrap_len(len)) return 2'd2;
`ifdef WLAST_CHECK_EN
      if (bad_last >= 0 && bad_last <= len) return 2'd2;
`endif
      return 2'd0;
   endfunction

   task automatic run_burst(input logic [31:0] a, input int len, input int sz, input int bt,
                            input logic [11:0] id, input int stall_pct, input int bdelay,
                            input int bad_last);
      int          t;
      int          i;
      int          cyc;
      logic        ok;
      logic        wv;
      logic [31:0] d;
      logic [3:0]  s;
      logic [1:0]  er;
      er = exp_resp(len, bt, bad_last);
      @(negedge clk);
      s_axi_awvalid = 1'b1;
      s_axi_awaddr  = a;
      s_axi_awlen   = len[7:0];
      s_axi_awsize  = sz[2:0];
      s_axi_awburst = bt[1:0];
      s_axi_awid    = id;
      t = 0;
      while (!s_axi_awready && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("aw_accept", s_axi_awready, 1);
      @(negedge clk);
      s_axi_awvalid = 1'b0;
      s_axi_awid    = ~id;
      i   = 0;
      cyc = 0;
      while (i <= len && cyc < 4000) begin
         ok = ($urandom_range(99) >= stall_pct);
         wv = ($urandom_range(99) < 85);
         d  = $urandom;
         s  = 4'($urandom);
         write_ready   = ok;
         s_axi_wvalid  = wv;
         s_axi_wdata   = d;
         s_axi_wstrb   = s;
         s_axi_wlast   = (i == len) ^ (i == bad_last);
         s_axi_awvalid = ($urandom_range(3) == 0);
         #1;
         chk("awready_busy", s_axi_awready, 0);
         chk("wready", s_axi_wready, ok);
         chk("wr_en", wr_en, wv & ok);
         if (wv && ok) begin
            chk("wr_addr", wr_addr, exp_addr(a, len, sz, bt, i));
            chk("wr_data", wr_data, d);
            chk("wr_strb", wr_strb, s);
            i++;
         end
         @(negedge clk);
         cyc++;
      end
      chk("beats_done", i, len + 1);
      s_axi_wvalid  = 1'b0;
      s_axi_awvalid = 1'b0;
      write_ready   = 1'b1;
      for (int k = 0; k < bdelay; k++) begin
         s_axi_bready = 1'b0;
         #1;
         chk("bvalid_hold", s_axi_bvalid, 1);
         chk("bid_hold", s_axi_bid, id);
         chk("bresp_hold", s_axi_bresp, er);
         chk("wready_resp", s_axi_wready, 0);
         @(negedge clk);
      end
      s_axi_bready = 1'b1;
      #1;
      chk("bvalid", s_axi_bvalid, 1);
      chk("bid", s_axi_bid, id);
      chk("bresp", s_axi_bresp, er);
      @(negedge clk);
      s_axi_bready = 1'b0;
      s_axi_wvalid = 1'b1;
      #1;
      chk("bvalid_clr", s_axi_bvalid, 0);
      chk("awready_idle", s_axi_awready, 1);
      chk("wready_idle", s_axi_wready, 0);
      chk("wr_en_idle", wr_en, 0);
      s_axi_wvalid = 1'b0;
   endtask

   initial begin
      int t;
      s_axi_aresetn = 1'b0;
      s_axi_awvalid = 1'b0;
      s_axi_awaddr  = '0;
      s_axi_awlen   = '0;
      s_axi_awsize  = '0;
      s_axi_awburst = '0;
      s_axi_awid    = '0;
      s_axi_wvalid  = 1'b1;
      s_axi_wdata   = '0;
      s_axi_wstrb   = '0;
      s_axi_wlast   = 1'b0;
      s_axi_bready  = 1'b1;
      write_ready   = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_awready", s_axi_awready, 0);
      chk("rst_bvalid", s_axi_bvalid, 0);
      chk("rst_bid", s_axi_bid, 0);
      chk("rst_bresp", s_axi_bresp, 0);
      chk("rst_wready", s_axi_wready, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_addr", wr_addr, 0);
      @(negedge clk);
      s_axi_aresetn = 1'b1;
      s_axi_wvalid  = 1'b0;
      s_axi_bready  = 1'b0;
      #1;
      chk("awready_rel", s_axi_awready, 0);
      @(negedge clk);
      #1;
      chk("awready_up", s_axi_awready, 1);

      run_burst(32'h100, 3, 2, 1, 12'h5A5, 0, 0, -1);
      run_burst(32'h1C,  3, 2, 2, 12'h123, 0, 0, -1);
      run_burst(32'h40,  2, 2, 0, 12'h7FF, 50, 1, -1);
      run_burst(32'h80,  3, 2, 3, 12'h001, 0, 0, -1);
      run_burst(32'h90,  2, 2, 2, 12'h002, 0, 0, -1);
      run_burst(32'h300, 1, 2, 1, 12'hABC, 0, 5, -1);
      run_burst(32'h200, 3, 2, 1, 12'h010, 0, 0, 1);
      run_burst(32'h200, 3, 2, 1, 12'h011, 0, 0, -1);
      run_burst(32'hFFFF_FFF8, 3, 2, 1, 12'h0F0, 20, 0, -1);

      // Reset in the middle of a burst
      @(negedge clk);
      s_axi_awvalid = 1'b1;
      s_axi_awaddr  = 32'h500;
      s_axi_awlen   = 8'd7;
      s_axi_awsize  = 3'd2;
      s_axi_awburst = 2'd1;
      s_axi_awid    = 12'h321;
      t = 0;
      while (!s_axi_awready && t < 50) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      s_axi_awvalid = 1'b0;
      s_axi_wvalid  = 1'b1;
      write_ready   = 1'b1;
      repeat (2) @(negedge clk);
      s_axi_aresetn = 1'b0;
      #1;
      chk("mid_rst_awready", s_axi_awready, 0);
      chk("mid_rst_bvalid", s_axi_bvalid, 0);
      chk("mid_rst_wready", s_axi_wready, 0);
      chk("mid_rst_wr_addr", wr_addr, 0);
      @(negedge clk);
      s_axi_aresetn = 1'b1;
      s_axi_wvalid  = 1'b0;
      @(negedge clk);
      #1;
      chk("post_rst_awready", s_axi_awready, 1);
      chk("post_rst_bvalid", s_axi_bvalid, 0);
      run_burst(32'h600, 3, 2, 1, 12'h456, 0, 0, -1);

      for (int n = 0; n < 40; n++) begin
         int bt;
         int len;
         int bad;
         bt = $urandom_range(3);
         if (bt == 2 && $urandom_range(1) == 1) begin
            case ($urandom_range(3))
               0: len = 1;
               1: len = 3;
               2: len = 7;
               default: len = 15;
            endcase
         end else begin
            len = $urandom_range(15);
         end
         bad = ($urandom_range(3) == 0) ? int'($urandom_range(len)) : -1;
         run_burst($urandom, len, $urandom_range(2), bt, 12'($urandom),
                   $urandom_range(60), $urandom_range(3), bad);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
